// File: rtl/sfx_sequencer.sv
// ---------------------------------------------------------------------------
// sfx_sequencer
//
// Sound-effect sequencer sitting between the game logic and note_gen. Jump,
// land and game-over event toggles arrive from the pixel-clock domain, are
// synchronised here, and each event plays a short fixed melody from an
// internal note ROM. The block drives the half-period divider that note_gen
// turns into a square wave for speaker_control.
//
// Parameters:
//   CLK_HZ       system clock rate; ROM dividers are CLK_HZ/(2*f), truncated
//   TICK_CYCLES  clocks per duration tick (1 ms at 100 MHz by default)
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   jump_tgl   in   1   jump event toggle (async, any transition = event)
//   land_tgl   in   1   land event toggle (async)
//   over_tgl   in   1   game-over event toggle (async)
//   mute       in   1   synchronous level; forces silence, timing unaffected
//   note_div   out  22  half-period divider, 22'd1 means silence
//   busy       out  1   high while a melody is in progress
//   sfx_id     out  2   0 none, 1 jump, 2 land, 3 game over
//
// Build option:
//   SFX_GAP_EN  when defined, a silent 10-tick gap separates consecutive
//               notes of a melody (GAP state). Undefined: notes play
//               back-to-back and the GAP state is not built.
// ---------------------------------------------------------------------------
module sfx_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_tgl,
    input  logic        land_tgl,
    input  logic        over_tgl,
    input  logic        mute,
    output logic [21:0] note_div,
    output logic        busy,
    output logic [1:0]  sfx_id
);

    // Prescaler width; at least one bit so TICK_CYCLES = 1 still elaborates.
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [8:0]    GAP_TICKS  = 9'd10;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_JUMP = 2'd1;
    localparam logic [1:0] ID_LAND = 2'd2;
    localparam logic [1:0] ID_OVER = 2'd3;

    localparam logic [21:0] DIV_SILENT = 22'd1;
    localparam logic [21:0] DIV_C5     = 22'(CLK_HZ / (2 * 523));
    localparam logic [21:0] DIV_E5     = 22'(CLK_HZ / (2 * 659));
    localparam logic [21:0] DIV_G4     = 22'(CLK_HZ / (2 * 392));
    localparam logic [21:0] DIV_E4     = 22'(CLK_HZ / (2 * 330));
    localparam logic [21:0] DIV_D4     = 22'(CLK_HZ / (2 * 294));
    localparam logic [21:0] DIV_C4     = 22'(CLK_HZ / (2 * 262));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1
`ifdef SFX_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_t;

    // Note ROM: divider per (melody, note index).
    function automatic logic [21:0] romDiv(input logic [1:0] id, input logic [1:0] idx);
        logic [21:0] d;
        d = DIV_SILENT;
        case (id)
            ID_JUMP: d = (idx == 2'd0) ? DIV_C5 : DIV_E5;
            ID_LAND: d = DIV_G4;
            ID_OVER: begin
                case (idx)
                    2'd0:    d = DIV_E4;
                    2'd1:    d = DIV_D4;
                    default: d = DIV_C4;
                endcase
            end
            default: d = DIV_SILENT;
        endcase
        return d;
    endfunction

    // Note ROM: duration in ticks per (melody, note index).
    function automatic logic [8:0] romDur(input logic [1:0] id, input logic [1:0] idx);
        logic [8:0] t;
        t = 9'd1;
        case (id)
            ID_JUMP: t = 9'd40;
            ID_LAND: t = 9'd30;
            ID_OVER: t = (idx == 2'd2) ? 9'd300 : 9'd150;
            default: t = 9'd1;
        endcase
        return t;
    endfunction

    // Note ROM: number of notes in each melody.
    function automatic logic [1:0] romLen(input logic [1:0] id);
        logic [1:0] n;
        n = 2'd1;
        case (id)
            ID_JUMP: n = 2'd2;
            ID_LAND: n = 2'd1;
            ID_OVER: n = 2'd3;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

    logic [2:0]    sync0_q;
    logic [2:0]    sync1_q;
    logic [2:0]    prev_q;
    logic [1:0]    armCnt_q;
    logic          armed;
    logic [2:0]    ev;
    logic [1:0]    evId;
    logic          start;

    state_t        state_q, state_d;
    logic [1:0]    melody_q, melody_d;
    logic [1:0]    note_q, note_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    dur_q, dur_d;
    logic          tickWrap;
    logic [8:0]    durNext;
    logic [1:0]    noteNext;

    logic [21:0]   noteDiv_q, noteDiv_d;
    logic          busy_q, busy_d;
    logic [1:0]    sfxId_q, sfxId_d;

    // Two-flop synchronisers plus a previous-value register per toggle,
    // packed as {over, land, jump}. The arm counter blanks strobes until the
    // chain has refilled after reset, so a toggle that sits at 1 through
    // reset is not mistaken for a fresh event when reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q  <= 3'b000;
            sync1_q  <= 3'b000;
            prev_q   <= 3'b000;
            armCnt_q <= 2'd0;
        end else begin
            sync0_q <= {over_tgl, land_tgl, jump_tgl};
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
            if (armCnt_q != 2'd3) begin
                armCnt_q <= armCnt_q + 2'd1;
            end
        end
    end

    assign armed = (armCnt_q == 2'd3);
    assign ev    = (sync1_q ^ prev_q) & {3{armed}};

    // Only the highest-priority strobe of a cycle is considered; equal or
    // higher priority than the playing melody restarts, lower is dropped.
    // melody_q is zero while idle, so any strobe starts from IDLE.
    always_comb begin
        evId = ID_NONE;
        if (ev[2]) begin
            evId = ID_OVER;
        end else if (ev[1]) begin
            evId = ID_LAND;
        end else if (ev[0]) begin
            evId = ID_JUMP;
        end
    end

    assign start    = (evId != ID_NONE) && (evId >= melody_q);
    assign tickWrap = (presc_q == PRESC_LAST);
    assign durNext  = dur_q + 9'd1;
    assign noteNext = note_q + 2'd1;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            melody_q <= ID_NONE;
            note_q   <= 2'd0;
            presc_q  <= '0;
            dur_q    <= 9'd0;
        end else begin
            state_q  <= state_d;
            melody_q <= melody_d;
            note_q   <= note_d;
            presc_q  <= presc_d;
            dur_q    <= dur_d;
        end
    end

    // Next-state logic. The prescaler and duration counter run in every
    // non-idle state and are cleared whenever a note or gap ends, so each
    // segment lasts exactly its tick count times TICK_CYCLES clocks. An
    // accepted strobe overrides everything and lands on note 0 in PLAY.
    always_comb begin
        state_d  = state_q;
        melody_d = melody_q;
        note_d   = note_q;
        presc_d  = presc_q;
        dur_d    = dur_q;

        if (state_q != IDLE) begin
            if (tickWrap) begin
                presc_d = '0;
                dur_d   = durNext;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        case (state_q)
            PLAY: begin
                if (tickWrap && (durNext == romDur(melody_q, note_q))) begin
                    presc_d = '0;
                    dur_d   = 9'd0;
                    if (noteNext < romLen(melody_q)) begin
`ifdef SFX_GAP_EN
                        state_d = GAP;
`else
                        note_d  = noteNext;
`endif
                    end else begin
                        state_d  = IDLE;
                        melody_d = ID_NONE;
                        note_d   = 2'd0;
                    end
                end
            end
`ifdef SFX_GAP_EN
            GAP: begin
                if (tickWrap && (durNext == GAP_TICKS)) begin
                    state_d = PLAY;
                    note_d  = noteNext;
                    presc_d = '0;
                    dur_d   = 9'd0;
                end
            end
`endif
            default: begin
            end
        endcase

        if (start) begin
            state_d  = PLAY;
            melody_d = evId;
            note_d   = 2'd0;
            presc_d  = '0;
            dur_d    = 9'd0;
        end
    end

    // Outputs are computed from the next state so they change on the same
    // edge as the state itself; busy and the divider drop together at the
    // end of the last note.
    always_comb begin
        busy_d    = (state_d != IDLE);
        sfxId_d   = melody_d;
        noteDiv_d = DIV_SILENT;
        if ((state_d == PLAY) && !mute) begin
            noteDiv_d = romDiv(melody_d, note_d);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noteDiv_q <= DIV_SILENT;
            busy_q    <= 1'b0;
            sfxId_q   <= ID_NONE;
        end else begin
            noteDiv_q <= noteDiv_d;
            busy_q    <= busy_d;
            sfxId_q   <= sfxId_d;
        end
    end

    assign note_div = noteDiv_q;
    assign busy     = busy_q;
    assign sfx_id   = sfxId_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sfx_sequencer
//
// Bench for sfx_sequencer with TICK_CYCLES = 10. A schedule model records
// when each melody started and derives the expected outputs from the time
// elapsed since then, walking the melody's note list. Directed scenarios
// add hand-computed checkpoints on top of the per-cycle model comparison.
// Honours SFX_GAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sfx_sequencer;

    localparam int T = 10;
`ifdef SFX_GAP_EN
    localparam int GAP_CLK = 10 * T;
`else
    localparam int GAP_CLK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        jump_tgl = 1'b0;
    logic        land_tgl = 1'b0;
    logic        over_tgl = 1'b0;
    logic        mute = 1'b0;
    logic [21:0] note_div;
    logic        busy;
    logic [1:0]  sfx_id;

    int compared = 0;
    int mismatched = 0;
    int modelFails = 0;

    sfx_sequencer #(
        .CLK_HZ      (100_000_000),
        .TICK_CYCLES (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .jump_tgl (jump_tgl),
        .land_tgl (land_tgl),
        .over_tgl (over_tgl),
        .mute     (mute),
        .note_div (note_div),
        .busy     (busy),
        .sfx_id   (sfx_id)
    );

    always #5 clk = ~clk;

    // Melody table: dividers and durations (ticks) per id, note count per id.
    int melDiv [4][3] = '{'{1, 1, 1}, '{95602, 75872, 1}, '{127551, 1, 1}, '{151515, 170068, 190839}};
    int melDur [4][3] = '{'{0, 0, 0}, '{40, 40, 0}, '{30, 0, 0}, '{150, 150, 300}};
    int melLen [4]    = '{0, 2, 1, 3};

    // Total length of a melody in clocks, gaps included.
    function automatic int melodyLength(input int id);
        int total;
        total = 0;
        for (int i = 0; i < melLen[id]; i++) begin
            total += melDur[id][i] * T;
            if (i < melLen[id] - 1) total += GAP_CLK;
        end
        return total;
    endfunction

    // Divider that must be sounding a given number of clocks into a melody.
    function automatic int divAt(input int id, input int elapsed);
        int e;
        e = elapsed;
        for (int i = 0; i < melLen[id]; i++) begin
            if (e < melDur[id][i] * T) return melDiv[id][i];
            e -= melDur[id][i] * T;
            if (i < melLen[id] - 1) begin
                if (e < GAP_CLK) return 1;
                e -= GAP_CLK;
            end
        end
        return 1;
    endfunction

    int          cycle = 0;
    int          curId = 0;
    int          startCyc = 0;
    int          evId;
    logic [2:0]  ev;
    logic [2:0]  h0 = 3'b000, h1 = 3'b000, h2 = 3'b000, h3 = 3'b000;
    logic [21:0] expDiv = 22'd1;
    logic        expBusy = 1'b0;
    logic [1:0]  expId = 2'd0;

    // Schedule model, advanced on each rising edge. A toggle change sampled
    // at edge n-2 takes effect on the outputs at edge n.
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            if (!rst_n) begin
                curId = 0;
                h0 = {over_tgl, land_tgl, jump_tgl};
                h1 = h0;
                h2 = h0;
                h3 = h0;
                expDiv = 22'd1;
                expBusy = 1'b0;
                expId = 2'd0;
            end else begin
                h3 = h2;
                h2 = h1;
                h1 = h0;
                h0 = {over_tgl, land_tgl, jump_tgl};
                ev = h2 ^ h3;
                if (curId != 0 && (cycle - 1 - startCyc) >= melodyLength(curId)) curId = 0;
                evId = ev[2] ? 3 : (ev[1] ? 2 : (ev[0] ? 1 : 0));
                if (evId != 0 && evId >= curId) begin
                    curId = evId;
                    startCyc = cycle;
                end
                if (curId != 0 && (cycle - startCyc) < melodyLength(curId)) begin
                    expBusy = 1'b1;
                    expId = 2'(curId);
                    expDiv = mute ? 22'd1 : 22'(divAt(curId, cycle - startCyc));
                end else begin
                    curId = 0;
                    expBusy = 1'b0;
                    expId = 2'd0;
                    expDiv = 22'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            compared++;
            if (note_div !== expDiv || busy !== expBusy || sfx_id !== expId) begin
                mismatched++;
                modelFails++;
                if (modelFails <= 20)
                    $display("[TB] FAIL model cycle %0d: got div=%0d busy=%0b id=%0d, want div=%0d busy=%0b id=%0d",
                             cycle, note_div, busy, sfx_id, expDiv, expBusy, expId);
            end
        end
    end

    task automatic checkOutput(input string name, input int wDiv, input logic wBusy, input int wId);
        compared++;
        if (note_div !== 22'(wDiv) || busy !== wBusy || sfx_id !== 2'(wId)) begin
            mismatched++;
            $display("[TB] FAIL %s: got div=%0d busy=%0b id=%0d, want div=%0d busy=%0b id=%0d",
                     name, note_div, busy, sfx_id, wDiv, wBusy, wId);
        end
    endtask

    // Toggles the selected inputs {over, land, jump} and sets mute, on a
    // falling edge so the next rising edge samples them cleanly.
    task automatic applyStimulus(input logic [2:0] tgl, input logic muteVal);
        @(negedge clk);
        if (tgl[0]) jump_tgl = ~jump_tgl;
        if (tgl[1]) land_tgl = ~land_tgl;
        if (tgl[2]) over_tgl = ~over_tgl;
        mute = muteVal;
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        waitClk(3);
        checkOutput("reset state", 1, 1'b0, 0);
        rst_n = 1'b1;
        waitClk(10);
        checkOutput("idle after release", 1, 1'b0, 0);

        // Jump melody: C5 then E5, 40 ticks each.
        applyStimulus(3'b001, 1'b0);
        waitClk(3);
        checkOutput("jump note0 start", 95602, 1'b1, 1);
        waitClk(399);
        checkOutput("jump note0 last clk", 95602, 1'b1, 1);
        waitClk(1);
`ifdef SFX_GAP_EN
        checkOutput("jump gap", 1, 1'b1, 1);
        waitClk(100);
`endif
        checkOutput("jump note1 start", 75872, 1'b1, 1);
        waitClk(399);
        checkOutput("jump note1 last clk", 75872, 1'b1, 1);
        waitClk(1);
        checkOutput("jump finished", 1, 1'b0, 0);
        waitClk(20);

        // Land and game over together: game over wins.
        applyStimulus(3'b110, 1'b0);
        waitClk(3);
        checkOutput("over beats land", 151515, 1'b1, 3);

        // Lower-priority jump is ignored; game over retriggers at 2000 clk.
        waitClk(597);
        applyStimulus(3'b001, 1'b0);
        waitClk(3);
        checkOutput("jump ignored", 151515, 1'b1, 3);
        waitClk(1395);
        applyStimulus(3'b100, 1'b0);
        waitClk(2);
        checkOutput("over note1 before retrigger", 170068, 1'b1, 3);
        waitClk(1);
        checkOutput("over retrigger", 151515, 1'b1, 3);
        waitClk(1499);
        checkOutput("over full first note", 151515, 1'b1, 3);
        waitClk(1);
`ifdef SFX_GAP_EN
        checkOutput("over gap after retrigger", 1, 1'b1, 3);
`else
        checkOutput("over note1 after retrigger", 170068, 1'b1, 3);
`endif
        waitClk(4499 + 2 * GAP_CLK);
        checkOutput("over last clk", 190839, 1'b1, 3);
        waitClk(1);
        checkOutput("over finished", 1, 1'b0, 0);
        waitClk(20);

        // Land preempts jump.
        applyStimulus(3'b001, 1'b0);
        waitClk(3);
        checkOutput("jump before preempt", 95602, 1'b1, 1);
        waitClk(100);
        applyStimulus(3'b010, 1'b0);
        waitClk(3);
        checkOutput("land preempts", 127551, 1'b1, 2);
        waitClk(299);
        checkOutput("land last clk", 127551, 1'b1, 2);
        waitClk(1);
        checkOutput("land finished", 1, 1'b0, 0);
        waitClk(20);

        // Muted land: silent but busy for exactly 300 clocks.
        applyStimulus(3'b010, 1'b1);
        waitClk(3);
        checkOutput("muted land start", 1, 1'b1, 2);
        waitClk(299);
        checkOutput("muted land last clk", 1, 1'b1, 2);
        waitClk(1);
        checkOutput("muted land finished", 1, 1'b0, 0);
        applyStimulus(3'b000, 1'b0);
        waitClk(20);

        // Mute toggled mid-note takes effect on the next edge.
        applyStimulus(3'b001, 1'b0);
        waitClk(50);
        applyStimulus(3'b000, 1'b1);
        waitClk(1);
        checkOutput("mute mid-note", 1, 1'b1, 1);
        applyStimulus(3'b000, 1'b0);
        waitClk(1);
        checkOutput("unmute mid-note", 95602, 1'b1, 1);
        waitClk(900);
        checkOutput("jump after mute finished", 1, 1'b0, 0);

        // Asynchronous reset mid-note; land and over sit at 1 through reset.
        applyStimulus(3'b100, 1'b0);
        waitClk(3);
        checkOutput("over before reset", 151515, 1'b1, 3);
        waitClk(50);
        #1 rst_n = 1'b0;
        #1 checkOutput("async reset", 1, 1'b0, 0);
        waitClk(3);
        rst_n = 1'b1;
        waitClk(60);
        checkOutput("no event after release", 1, 1'b0, 0);

        applyStimulus(3'b001, 1'b0);
        waitClk(3);
        checkOutput("jump after reset", 95602, 1'b1, 1);
        waitClk(900);
        checkOutput("final idle", 1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
